pwm_compare_deadtime_16bits: RTL and testbench

Consumer end of the carrier path. Compares the 16-bit carrier against a shadowed compare value, producing a raw PWM reference. A dead-time state machine expands that reference into a complementary high-side/low-side gate pair with break-before-make guarantees. One instance per switching leg, driven by the carrier and `maskevent` outputs of a carrier channel.

---
 rtl/pwm_compare_deadtime_16bits_pkg.sv | 28 ++
 rtl/pwm_compare_deadtime_16bits_if.sv | 27 ++
 rtl/pwm_compare_deadtime_16bits_deadtime_fsm.sv | 117 +++++++++++
 rtl/pwm_compare_deadtime_16bits.sv | 57 +++++
 tb/tb_pwm_compare_deadtime_16bits.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/pwm_compare_deadtime_16bits_pkg.sv
// Shared types and constants for the PWM compare / dead-time leg.
// Optional feature macro: PWM_DEADTIME_EN (dead-time FSM; default build
// drives the gates straight from the registered reference).
package pwm_compare_deadtime_16bits_pkg;

  localparam int PWMCOUNT_WIDTH = 16;
  localparam int DTCOUNT_WIDTH  = 10;

  typedef enum logic {
    PWM_OFF = 1'b0,
    PWM_ON  = 1'b1
  } _pwm_onoff;

  typedef enum logic [2:0] {
    DT_OFF   = 3'd0,
    DT_START = 3'd1,
    DT_H_ON  = 3'd2,
    DT_HL    = 3'd3,
    DT_L_ON  = 3'd4,
    DT_LH    = 3'd5
  } _dt_state;

  // True for the states in which both gates are held off while dt_cnt runs.
  function automatic logic is_dt_state(input _dt_state s);
    return (s == DT_START) || (s == DT_HL) || (s == DT_LH);
  endfunction

endpackage

// File: rtl/pwm_compare_deadtime_16bits_if.sv
// Bus bundle between a carrier channel / register block and one PWM leg.
// Optional feature macro: PWM_DEADTIME_EN (does not change this bundle).
interface pwm_compare_deadtime_16bits_if
  import pwm_compare_deadtime_16bits_pkg::*;
  #(parameter int DT_WIDTH = DTCOUNT_WIDTH);

  logic [PWMCOUNT_WIDTH-1:0] carrier;
  logic                      maskevent;
  logic [PWMCOUNT_WIDTH-1:0] compare;
  logic [DT_WIDTH-1:0]       deadtime;
  _pwm_onoff                 pwm_onoff;
  logic                      polarity;
  logic                      pwm_h;
  logic                      pwm_l;
  logic                      cmp_match;

  modport master (
    output carrier, maskevent, compare, deadtime, pwm_onoff, polarity,
    input  pwm_h, pwm_l, cmp_match
  );

  modport slave (
    input  carrier, maskevent, compare, deadtime, pwm_onoff, polarity,
    output pwm_h, pwm_l, cmp_match
  );

endinterface

// File: rtl/pwm_compare_deadtime_16bits_deadtime_fsm.sv
// Expands the registered PWM reference into a complementary gate pair.
// Optional feature macro: PWM_DEADTIME_EN. When defined, a six-state FSM
// inserts a dead band on every swap; otherwise one output register stage
// follows the reference directly with the same latency.
module deadtime_fsm
  import pwm_compare_deadtime_16bits_pkg::*;
  #(parameter int DT_WIDTH = DTCOUNT_WIDTH)
  (
    input  logic                clk,
    input  logic                reset,
    input  logic                ref_q,
    input  logic [DT_WIDTH-1:0] deadtime,
    input  _pwm_onoff           pwm_onoff,
    input  logic                polarity,
    output logic                pwm_h,
    output logic                pwm_l
  );

`ifdef PWM_DEADTIME_EN

  _dt_state            state_r;
  _dt_state            state_next_s;
  logic [DT_WIDTH-1:0] dt_cnt_r;
  logic [DT_WIDTH-1:0] dt_cnt_next_s;
  logic                dt_zero_s;

  assign dt_zero_s = (dt_cnt_r == '0);

  // State and dead-time counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= DT_OFF;
      dt_cnt_r <= '0;
    end else begin
      state_r  <= state_next_s;
      dt_cnt_r <= dt_cnt_next_s;
    end
  end

  // Next state; disable wins over everything, aborts follow the reference.
  always_comb begin
    state_next_s = state_r;
    if (pwm_onoff == PWM_OFF) begin
      state_next_s = DT_OFF;
    end else begin
      case (state_r)
        DT_OFF:   state_next_s = DT_START;
        DT_START: begin
          if (dt_zero_s) state_next_s = ref_q ? DT_H_ON : DT_L_ON;
          else           state_next_s = DT_START;
        end
        DT_H_ON: begin
          if (!ref_q) state_next_s = DT_HL;
          else        state_next_s = DT_H_ON;
        end
        DT_HL: begin
          if (ref_q)          state_next_s = DT_H_ON;
          else if (dt_zero_s) state_next_s = DT_L_ON;
          else                state_next_s = DT_HL;
        end
        DT_L_ON: begin
          if (ref_q) state_next_s = DT_LH;
          else       state_next_s = DT_L_ON;
        end
        DT_LH: begin
          if (!ref_q)         state_next_s = DT_L_ON;
          else if (dt_zero_s) state_next_s = DT_H_ON;
          else                state_next_s = DT_LH;
        end
        default: state_next_s = DT_OFF;
      endcase
    end
  end

  // Counter loads the dead band on DT entry and counts down while inside.
  always_comb begin
    dt_cnt_next_s = dt_cnt_r;
    if (is_dt_state(state_next_s) && (state_next_s != state_r)) begin
      dt_cnt_next_s = deadtime;
    end else if (is_dt_state(state_r) && !dt_zero_s) begin
      dt_cnt_next_s = dt_cnt_r - DT_WIDTH'(1);
    end else begin
      dt_cnt_next_s = dt_cnt_r;
    end
  end

  assign pwm_h = (state_r == DT_H_ON) ^ polarity;
  assign pwm_l = (state_r == DT_L_ON) ^ polarity;

`else

  logic h_on_r;
  logic l_on_r;
  logic dt_unused_s;

  assign dt_unused_s = ^deadtime;

  // Output stage standing in for the state register: complementary gates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_on_r <= 1'b0;
      l_on_r <= 1'b0;
    end else if (pwm_onoff == PWM_ON) begin
      h_on_r <= ref_q;
      l_on_r <= ~ref_q;
    end else begin
      h_on_r <= 1'b0;
      l_on_r <= 1'b0;
    end
  end

  assign pwm_h = h_on_r ^ polarity;
  assign pwm_l = l_on_r ^ polarity;

`endif

endmodule

// File: rtl/pwm_compare_deadtime_16bits.sv
// PWM leg: shadowed compare register, registered carrier comparator and
// edge pulse, feeding the dead-time gate generator.
// Optional feature macro: PWM_DEADTIME_EN (see deadtime_fsm).
module pwm_compare_deadtime_16bits
  import pwm_compare_deadtime_16bits_pkg::*;
  #(parameter int DT_WIDTH = DTCOUNT_WIDTH)
  (
    input  logic                         clk,
    input  logic                         reset,
    pwm_compare_deadtime_16bits_if.slave bus
  );

  logic [PWMCOUNT_WIDTH-1:0] compare_sh_r;
  logic                      ref_q_r;
  logic                      ref_next_s;
  logic                      cmp_match_r;
  logic                      pwm_on_s;

  assign pwm_on_s   = (bus.pwm_onoff == PWM_ON);
  assign ref_next_s = (bus.carrier < compare_sh_r);

  // Shadow compare: loads on the period strobe, transparent while the leg is off.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      compare_sh_r <= '0;
    end else if (bus.maskevent || !pwm_on_s) begin
      compare_sh_r <= bus.compare;
    end else begin
      compare_sh_r <= compare_sh_r;
    end
  end

  // Registered reference and a pulse coincident with each of its edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ref_q_r     <= 1'b0;
      cmp_match_r <= 1'b0;
    end else begin
      ref_q_r     <= ref_next_s;
      cmp_match_r <= (ref_next_s != ref_q_r) && pwm_on_s;
    end
  end

  assign bus.cmp_match = cmp_match_r;

  deadtime_fsm #(.DT_WIDTH(DT_WIDTH)) u_deadtime_fsm (
    .clk       (clk),
    .reset     (reset),
    .ref_q     (ref_q_r),
    .deadtime  (bus.deadtime),
    .pwm_onoff (bus.pwm_onoff),
    .polarity  (bus.polarity),
    .pwm_h     (bus.pwm_h),
    .pwm_l     (bus.pwm_l)
  );

endmodule

// File: tb/tb_pwm_compare_deadtime_16bits.sv
// Directed bench for one PWM leg driven by an up-ramp carrier 0..99.
// Expected values follow the build: PWM_DEADTIME_EN defined or not.
module tb_pwm_compare_deadtime_16bits;
  import pwm_compare_deadtime_16bits_pkg::*;

`ifdef PWM_DEADTIME_EN
  localparam bit DT_EN = 1'b1;
`else
  localparam bit DT_EN = 1'b0;
`endif
  localparam int PER = 100;
  localparam int DT  = 5;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  pwm_compare_deadtime_16bits_if bus ();

  pwm_compare_deadtime_16bits dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int car      = 0;
  bit mask_en  = 1'b1;
  int n_h, n_l, n_idle, n_both, n_match, n_lead;
  bit lead_open;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_h = 0; n_l = 0; n_idle = 0; n_both = 0; n_match = 0; n_lead = 0;
    lead_open = 1'b1;
  endtask

  // One carrier step: drive, clock, sample 1 time unit after the edge.
  task automatic tick();
    logic ah;
    logic al;
    bus.carrier   = 16'(car);
    bus.maskevent = mask_en && (car == PER - 1);
    @(posedge clk);
    #1;
    ah = bus.pwm_h ^ bus.polarity;
    al = bus.pwm_l ^ bus.polarity;
    if (ah) n_h++;
    if (al) n_l++;
    if (!ah && !al) n_idle++;
    if (ah && al) n_both++;
    if (bus.cmp_match === 1'b1) n_match++;
    if (lead_open) begin
      if (!ah && !al) n_lead++;
      else lead_open = 1'b0;
    end
    car = (car == PER - 1) ? 0 : car + 1;
  endtask

  task automatic window();
    clr();
    repeat (PER) tick();
  endtask

  task automatic settle();
    repeat (2) window();
  endtask

  initial begin
    bus.carrier   = 16'd0;
    bus.maskevent = 1'b0;
    bus.compare   = 16'd40;
    bus.deadtime  = 10'd5;
    bus.pwm_onoff = PWM_OFF;
    bus.polarity  = 1'b0;
    reset = 1'b0;
    #1;
    chk("reset_h", int'(bus.pwm_h), 0);
    chk("reset_l", int'(bus.pwm_l), 0);
    chk("reset_match", int'(bus.cmp_match), 0);
    bus.polarity = 1'b1;
    #1;
    chk("reset_pol_h", int'(bus.pwm_h), 1);
    chk("reset_pol_l", int'(bus.pwm_l), 1);
    bus.polarity = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    // Leg disabled: gates inactive, no match pulses.
    window();
    chk("off_active", n_h + n_l, 0);
    chk("off_match", n_match, 0);

    // Basic PWM, compare 40.
    bus.pwm_onoff = PWM_ON;
    settle();
    window();
    chk("basic_h", n_h, DT_EN ? 34 : 40);
    chk("basic_l", n_l, DT_EN ? 54 : 60);
    chk("basic_idle", n_idle, DT_EN ? 12 : 0);
    chk("basic_both", n_both, 0);
    chk("basic_match", n_match, 2);

    // Shadow update: mid-period change is held until the strobe.
    clr();
    repeat (50) tick();
    bus.compare = 16'd70;
    repeat (50) tick();
    chk("shadow_hold_h", n_h, DT_EN ? 34 : 40);
    window();
    chk("shadow_new_h", n_h, DT_EN ? 64 : 70);
    chk("shadow_new_l", n_l, DT_EN ? 24 : 30);

    // Narrow pulse shorter than the dead band.
    bus.compare = 16'd3;
    settle();
    window();
    chk("narrow_h", n_h, DT_EN ? 0 : 3);
    chk("narrow_l", n_l, 97);
    chk("narrow_match", n_match, 2);

    // Compare 0: reference never high.
    bus.compare = 16'd0;
    settle();
    window();
    chk("zero_h", n_h, 0);
    chk("zero_l", n_l, PER);
    chk("zero_match", n_match, 0);

    // Compare above carrier peak: reference always high.
    bus.compare = 16'd200;
    settle();
    window();
    chk("max_h", n_h, PER);
    chk("max_l", n_l, 0);
    chk("max_match", n_match, 0);

    // Disable mid high-side phase, then transparent shadow while off.
    bus.compare = 16'd40;
    settle();
    clr();
    repeat (10) tick();
    chk("pre_off_h", int'(bus.pwm_h ^ bus.polarity), 1);
    bus.pwm_onoff = PWM_OFF;
    tick();
    chk("dis_h", int'(bus.pwm_h ^ bus.polarity), 0);
    chk("dis_l", int'(bus.pwm_l ^ bus.polarity), 0);
    mask_en = 1'b0;
    bus.compare = 16'd25;
    clr();
    repeat (PER - 11) tick();
    chk("dis_active", n_h + n_l, 0);
    chk("dis_match", n_match, 0);

    // Re-enable without a strobe: shadow already holds 25.
    bus.pwm_onoff = PWM_ON;
    window();
    chk("reen_lead", n_lead, DT_EN ? DT + 1 : 0);
    chk("reen_h", n_h, DT_EN ? 20 : 25);

    // No strobe while on: compare change must not reach the reference.
    bus.compare = 16'd60;
    window();
    chk("nomask_h", n_h, DT_EN ? 19 : 25);
    mask_en = 1'b1;
    window();
    window();
    chk("mask_h", n_h, DT_EN ? 54 : 60);

    // Active-low gates.
    bus.polarity = 1'b1;
    bus.compare  = 16'd40;
    settle();
    window();
    chk("pol_h", n_h, DT_EN ? 34 : 40);
    chk("pol_l", n_l, DT_EN ? 54 : 60);

    // Reset in the low-to-high dead band (carrier just wrapped).
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk("rst_pol_h", int'(bus.pwm_h), 1);
    chk("rst_pol_l", int'(bus.pwm_l), 1);
    chk("rst_match", int'(bus.cmp_match), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rel_h", int'(bus.pwm_h), 1);
    chk("rel_l", int'(bus.pwm_l), 1);
    clr();
    repeat (20) tick();
    chk("rel_lead", n_lead, DT_EN ? DT + 1 : 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
